amp_spi_responder: RTL and testbench
====================================

// Module: amp_spi_responder
// PURPOSE
//   SPI responder (slave) model of the programmable preamp gain register; the far end of the amp gain-write link.
//   Oversamples SPI_CLK_AMP/AMP_CS/SPI_MOSI_AMP in the clk domain, captures an 8-bit MSB-first gain word,
//   commits it on CS release, echoes the previously held word on MISO. Used in board-level sim and FPGA loopback.
// PARAMETERS
//   WIDTH       8      frame length in bits; gain word = {gain_b, gain_a}, each WIDTH/2 bits
//   SYNC_STAGES 2      flip-flop synchronizer depth on each SPI input (>=2)
//   GAIN_RST    8'h00  gain register value after reset and while AMP_SHDN=1
// PORTS
//   clk           in   1  system clock; SPI_CLK_AMP period >= 4 clk
//   reset         in   1  asynchronous, active-low reset
//   SPI_CLK_AMP   in   1  SPI clock, idle low, data sampled on rising edge
//   SPI_MOSI_AMP  in   1  serial data in, MSB first
//   AMP_CS        in   1  chip select, active low
//   AMP_SHDN      in   1  shutdown, active high
//   SPI_MISO_AMP  out  1  serial data out (echo of previous gain word)
//   gain_a        out  4  committed gain, channel A (word[3:0])
//   gain_b        out  4  committed gain, channel B (word[7:4])
//   gain_valid    out  1  1-clk pulse when a new word commits
//   frame_err     out  1  1-clk pulse when a frame ends with bit count != WIDTH
//   busy          out  1  high while a frame is open (synchronized CS low)
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, gain reg=GAIN_RST, SPI_MISO_AMP=0, gain_valid=0, frame_err=0, busy=0,
//     synchronizers cleared to idle (CS=1, SCLK=0, MOSI=0). Release mid-frame: responder waits for next CS fall.
//   Edges detected on synchronized signals (prev vs current); detection latency SYNC_STAGES+1 clk.
//   FSM: IDLE -> SHIFT on CS fall: bit_cnt=0, tx_sr=gain reg, busy=1, MISO=tx_sr[WIDTH-1] next clk.
//     SHIFT: SCLK rise -> rx_sr={rx_sr[WIDTH-2:0],MOSI}, bit_cnt+1 (saturates at 15).
//            SCLK fall -> tx_sr<<=1, MISO=new tx_sr[WIDTH-1]; after WIDTH bits MISO shifts 0.
//     SHIFT -> COMMIT on CS rise; busy=0 same clk.
//     COMMIT (1 clk): bit_cnt==WIDTH and AMP_SHDN=0 -> gain reg=rx_sr, gain_valid=1 (outputs change same edge);
//            bit_cnt!=WIDTH -> frame_err=1, gain reg unchanged; -> IDLE. Min CS-high time 2 clk.
//   Simultaneous CS rise and SCLK edge in one clk: CS wins, edge ignored.
//   SCLK edges in IDLE ignored; MISO held 0 in IDLE.
//   AMP_SHDN=1: gain reg forced to GAIN_RST every clk, commits suppressed (no gain_valid), framing/frame_err
//     still active; echo loads GAIN_RST.
// CONFIGURATION
//   AMP_RESP_ECHO_EN defined: MISO echoes previous word as above.
//   Not defined: tx_sr removed, SPI_MISO_AMP tied 0; all other behaviour identical.
// STRUCTURE
//   Package amp_spi_pkg: WIDTH default, state enum {IDLE,SHIFT,COMMIT}, GAIN_RST default, bit_cnt width.
//   One sub-module: spi_in_sync (SYNC_STAGES-deep synchronizer + rise/fall detect), instanced for SCLK and CS;
//   MOSI uses synchronizer only, delay-matched to SCLK.
// TESTING
//   1 Master frame 8'h11 (CS low, 8 clocks, sclk 4 clk/half) -> gain_a=1, gain_b=1, one gain_valid, frame_err=0.
//   2 Then frame 8'h34 with echo on -> MISO bits 0,0,0,1,0,0,0,1; gain_a=4, gain_b=3 after commit.
//   3 5-bit frame then CS high -> frame_err pulse, gain_valid=0, gain stays 8'h34; 9-bit frame -> same.
//   4 reset=0 after 4 bits of 8'hA5 -> outputs to reset values immediately; next full 8'h22 frame commits cleanly.
//   5 AMP_SHDN=1, send 8'h77 -> gain_a=gain_b=0, no gain_valid; SHDN=0, resend 8'h77 -> gains 7/7.
//   6 CS rise same clk as last SCLK rise -> bit dropped, frame_err=1; echo undefined-free (MISO=0 in IDLE).

Source files
------------

// File: rtl/amp_spi_pkg.sv
// Shared constants and types for the amp gain SPI responder.
// Optional feature macro: AMP_RESP_ECHO_EN (MISO echo of the previously held word).
package amp_spi_pkg;

   localparam int unsigned WIDTH_DEF       = 8;
   localparam int unsigned SYNC_STAGES_DEF = 2;
   localparam logic [7:0]  GAIN_RST_DEF    = 8'h00;

   // Bit counter is wide enough to see frames longer than WIDTH; it saturates at all-ones.
   localparam int unsigned       CNT_W   = 4;
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_e;

   // Saturating increment of the received-bit counter.
   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
      return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
   endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-stage synchronizer for one SPI input with rise/fall detection on the synchronized level.
module spi_in_sync #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic rise_c,
   output logic fall_c
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              level;

   assign level = sync_q[STAGES-1];

   // Synchronizer chain plus one history flop for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= level;
      end
   end

   assign rise_c = level & ~prev_q;
   assign fall_c = ~level & prev_q;

endmodule

// File: rtl/amp_spi_responder.sv
// SPI responder for the programmable preamp gain register.
// Captures a WIDTH-bit MSB-first word, commits it on CS release, reports short/long frames.
// Optional feature macro: AMP_RESP_ECHO_EN -- when defined MISO echoes the previously
// held gain word; when undefined the echo shifter is absent and MISO is tied low.
module amp_spi_responder
   import amp_spi_pkg::*;
#(
   parameter int unsigned      WIDTH       = WIDTH_DEF,
   parameter int unsigned      SYNC_STAGES = SYNC_STAGES_DEF,
   parameter logic [WIDTH-1:0] GAIN_RST    = WIDTH'(GAIN_RST_DEF)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 SPI_CLK_AMP,
   input  logic                 SPI_MOSI_AMP,
   input  logic                 AMP_CS,
   input  logic                 AMP_SHDN,
   output logic                 SPI_MISO_AMP,
   output logic [WIDTH/2-1:0]   gain_a,
   output logic [WIDTH/2-1:0]   gain_b,
   output logic                 gain_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int unsigned HALF_W = WIDTH / 2;

   state_e               state_q;
   logic [CNT_W-1:0]     bit_cnt_q;
   logic [WIDTH-1:0]     rx_sr_q;
   logic [WIDTH-1:0]     gain_q;
   logic                 gain_valid_q;
   logic                 frame_err_q;
   logic                 busy_q;

   logic                 sclk_rise;
   logic                 sclk_fall;
   logic                 cs_rise;
   logic                 cs_fall;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                 mosi_s;

   spi_in_sync #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b0)
   ) u_sync_sclk (
      .clk    (clk),
      .reset  (reset),
      .d_i    (SPI_CLK_AMP),
      .rise_c (sclk_rise),
      .fall_c (sclk_fall)
   );

   spi_in_sync #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_sync_cs (
      .clk    (clk),
      .reset  (reset),
      .d_i    (AMP_CS),
      .rise_c (cs_rise),
      .fall_c (cs_fall)
   );

   // MOSI synchronizer, same depth as SCLK so data lines up with the detected rising edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mosi_sync_q <= '0;
      end else begin
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI_AMP};
      end
   end

   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // Frame FSM: open on CS fall, shift on SCLK rise, judge and commit on CS rise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         rx_sr_q      <= '0;
         gain_q       <= GAIN_RST;
         gain_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         gain_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               busy_q <= 1'b0;
               if (cs_fall) begin
                  state_q   <= SHIFT;
                  bit_cnt_q <= '0;
                  busy_q    <= 1'b1;
               end
            end
            SHIFT: begin
               // CS release takes priority over any SCLK edge seen in the same cycle.
               if (cs_rise) begin
                  state_q <= COMMIT;
                  busy_q  <= 1'b0;
               end else if (sclk_rise) begin
                  rx_sr_q   <= {rx_sr_q[WIDTH-2:0], mosi_s};
                  bit_cnt_q <= cnt_inc(bit_cnt_q);
               end
            end
            COMMIT: begin
               state_q <= IDLE;
               if (bit_cnt_q == CNT_W'(WIDTH)) begin
                  if (!AMP_SHDN) begin
                     gain_q       <= rx_sr_q;
                     gain_valid_q <= 1'b1;
                  end
               end else begin
                  frame_err_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
         // Shutdown pins the gain register regardless of frame activity.
         if (AMP_SHDN) begin
            gain_q <= GAIN_RST;
         end
      end
   end

`ifdef AMP_RESP_ECHO_EN
   logic [WIDTH-1:0] tx_sr_q;
   logic [WIDTH-1:0] tx_load;
   logic             miso_q;

   assign tx_load = AMP_SHDN ? GAIN_RST : gain_q;

   // Echo shifter: load the held word at frame start, advance on each SCLK fall, zero-fill.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_sr_q <= '0;
         miso_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  tx_sr_q <= tx_load;
                  miso_q  <= tx_load[WIDTH-1];
               end else begin
                  miso_q <= 1'b0;
               end
            end
            SHIFT: begin
               if (cs_rise) begin
                  miso_q <= 1'b0;
               end else if (sclk_fall) begin
                  tx_sr_q <= {tx_sr_q[WIDTH-2:0], 1'b0};
                  miso_q  <= tx_sr_q[WIDTH-2];
               end
            end
            default: begin
               miso_q <= 1'b0;
            end
         endcase
      end
   end

   assign SPI_MISO_AMP = miso_q;
`else
   // Falling SCLK edges only drive the echo shifter, which is absent in this build.
   logic unused_sclk_fall;
   assign unused_sclk_fall = sclk_fall;
   assign SPI_MISO_AMP     = 1'b0;
`endif

   assign gain_a     = gain_q[HALF_W-1:0];
   assign gain_b     = gain_q[WIDTH-1:HALF_W];
   assign gain_valid = gain_valid_q;
   assign frame_err  = frame_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_amp_spi_responder.sv
// Bench for amp_spi_responder: a bit-banged SPI master plus a word-level model of the gain register.
`timescale 1ns/1ps
module tb_amp_spi_responder;

   localparam int unsigned W    = 8;
   localparam int unsigned HALF = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic sclk  = 1'b0;
   logic mosi  = 1'b0;
   logic cs    = 1'b1;
   logic shdn  = 1'b0;

   logic       miso;
   logic [3:0] ga;
   logic [3:0] gb;
   logic       gv;
   logic       fe;
   logic       busy;

   amp_spi_responder dut (
      .clk          (clk),
      .reset        (reset),
      .SPI_CLK_AMP  (sclk),
      .SPI_MOSI_AMP (mosi),
      .AMP_CS       (cs),
      .AMP_SHDN     (shdn),
      .SPI_MISO_AMP (miso),
      .gain_a       (ga),
      .gain_b       (gb),
      .gain_valid   (gv),
      .frame_err    (fe),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int         total   = 0;
   int         bad     = 0;
   int         n_valid = 0;
   int         n_err   = 0;
   logic [7:0] exp_gain  = 8'h00;
   logic [7:0] pend_word = 8'h00;
   logic       shdn_seen = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Expected MISO during bit i of a frame that started while 'echo' was the held word.
   function automatic logic exp_miso(input logic [7:0] echo, input int i);
`ifdef AMP_RESP_ECHO_EN
      if (i < int'(W)) return echo[W-1-i];
      return 1'b0;
`else
      return 1'b0;
`endif
   endfunction

   // What the DUT saw for SHDN at the last active edge.
   always @(posedge clk) shdn_seen <= shdn;

   // Cycle checker: gain register model, pulse counting, reset values.
   always @(negedge clk) begin
      if (!reset) begin
         exp_gain = 8'h00;
         chk("rst_gain", 32'({gb, ga}), 32'h00);
         chk("rst_valid", 32'(gv), 32'h0);
         chk("rst_err", 32'(fe), 32'h0);
         chk("rst_busy", 32'(busy), 32'h0);
         chk("rst_miso", 32'(miso), 32'h0);
      end else begin
         if (gv) begin
            n_valid++;
            chk("valid_in_shdn", 32'(shdn_seen), 32'h0);
            exp_gain = pend_word;
         end else if (shdn_seen) begin
            exp_gain = 8'h00;
         end
         if (fe) n_err++;
         chk("gain", 32'({gb, ga}), 32'(exp_gain));
         if (gv && fe) chk("valid_and_err", 32'h1, 32'h0);
      end
   end

   // One master frame: nbits of w MSB-first; race raises CS together with the last SCLK rise.
   task automatic send_frame(input logic [31:0] w, input int nbits, input bit race,
                             output logic [31:0] miso_bits);
      logic [7:0] echo;
      int         eff;
      bit         good;
      int         v0;
      int         e0;
      echo      = exp_gain;
      eff       = race ? nbits - 1 : nbits;
      good      = (eff == int'(W));
      pend_word = 8'(w >> (nbits - eff));
      v0        = n_valid;
      e0        = n_err;
      miso_bits = '0;
      cs   = 1'b0;
      mosi = w[nbits-1];
      tick(HALF);
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b1;
         if (race && i == nbits - 1) cs = 1'b1;
         miso_bits = {miso_bits[30:0], miso};
         chk("miso_bit", 32'(miso), 32'(exp_miso(echo, i)));
         if (!(race && i == nbits - 1)) chk("busy_in_frame", 32'(busy), 32'h1);
         tick(HALF);
         sclk = 1'b0;
         if (i < nbits - 1) mosi = w[nbits-2-i];
         tick(HALF);
      end
      cs = 1'b1;
      tick(8);
      chk("valid_count", 32'(n_valid - v0), 32'(good && !shdn));
      chk("err_count", 32'(n_err - e0), 32'(!good));
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_miso", 32'(miso), 32'h0);
      tick(2);
   endtask

   initial begin
      logic [31:0] mb;
      logic [7:0]  a5;
      a5 = 8'hA5;

      // Reset state
      tick(3);
      chk("por_gain", 32'({gb, ga}), 32'h00);
      chk("por_busy", 32'(busy), 32'h0);
      reset = 1'b1;
      tick(3);

      // Plain 8-bit frame
      send_frame(32'h11, 8, 1'b0, mb);
      chk("t1_gain_a", 32'(ga), 32'h1);
      chk("t1_gain_b", 32'(gb), 32'h1);
      chk("t1_echo", 32'(mb[7:0]), 32'h00);

      // Second frame echoes the first word
      send_frame(32'h34, 8, 1'b0, mb);
`ifdef AMP_RESP_ECHO_EN
      chk("t2_echo", 32'(mb[7:0]), 32'h11);
`else
      chk("t2_echo", 32'(mb[7:0]), 32'h00);
`endif
      chk("t2_gain_a", 32'(ga), 32'h4);
      chk("t2_gain_b", 32'(gb), 32'h3);

      // Short, long and saturating frames leave the gain alone
      send_frame(32'h1F, 5, 1'b0, mb);
      chk("t3_short_gain", 32'({gb, ga}), 32'h34);
      send_frame(32'h1C3, 9, 1'b0, mb);
      chk("t3_long_gain", 32'({gb, ga}), 32'h34);
      send_frame(32'h1ABCD, 17, 1'b0, mb);
      chk("t3_sat_gain", 32'({gb, ga}), 32'h34);

      // Asynchronous reset in the middle of a frame
      cs   = 1'b0;
      mosi = a5[7];
      tick(HALF);
      for (int i = 0; i < 4; i++) begin
         sclk = 1'b1;
         tick(HALF);
         sclk = 1'b0;
         mosi = a5[6-i];
         tick(HALF);
      end
      #1 reset = 1'b0;
      #1;
      chk("t4_async_gain", 32'({gb, ga}), 32'h00);
      chk("t4_async_busy", 32'(busy), 32'h0);
      chk("t4_async_miso", 32'(miso), 32'h0);
      cs   = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      tick(3);
      reset = 1'b1;
      tick(3);
      send_frame(32'h22, 8, 1'b0, mb);
      chk("t4_gain", 32'({gb, ga}), 32'h22);

      // Shutdown suppresses the commit, then the same word lands
      shdn = 1'b1;
      tick(2);
      chk("t5_shdn_gain", 32'({gb, ga}), 32'h00);
      send_frame(32'h77, 8, 1'b0, mb);
      chk("t5_shdn_echo", 32'(mb[7:0]), 32'h00);
      chk("t5_shdn_gain2", 32'({gb, ga}), 32'h00);
      shdn = 1'b0;
      tick(2);
      send_frame(32'h77, 8, 1'b0, mb);
      chk("t5_gain_a", 32'(ga), 32'h7);
      chk("t5_gain_b", 32'(gb), 32'h7);

      // CS rise coincident with the last SCLK rise drops that bit
      send_frame(32'h5A, 8, 1'b1, mb);
      chk("t6_gain", 32'({gb, ga}), 32'h77);

      // Randomized frames
      for (int k = 0; k < 20; k++) begin
         int          nb;
         bit          rc;
         bit          sd;
         logic [31:0] w;
         w  = $urandom;
         nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, 12)) : 8;
         rc = ($urandom_range(0, 5) == 0);
         sd = ($urandom_range(0, 6) == 0);
         if (sd) begin
            shdn = 1'b1;
            tick(2);
         end
         send_frame(w, nb, rc, mb);
         shdn = 1'b0;
         tick(2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
